team_06_i2s_to_dac: RTL
=======================

// Module: team_06_i2s_to_dac
// PURPOSE
//  I2S transmitter: the DAC-side counterpart of the ADC-to-I2S receive path.
//  Accepts signed 8-bit samples over a valid/ready handshake and buffers one sample.
//  Generates the bit clock (sclk) and word select (ws), and shifts sd out MSB first.
//  Format is Philips I2S, 64-bit frame (2 x 32-bit slots), mono: the same sample is
//  sent on the left (ws=0) and right (ws=1) slots.
// PARAMETERS
//  CLK_DIV   4   clk cycles per sclk half-period (>=2); sclk period = 2*CLK_DIV clk
//  SAMPLE_W  8   sample width; left-justified in each 32-bit slot (<=32)
// PORTS
//  clk           in   1         system clock
//  rst           in   1         synchronous, active-high reset
//  enable        in   1         run request; level-sensitive
//  sample_in     in   SAMPLE_W  signed sample to transmit
//  sample_valid  in   1         sample_in valid this cycle
//  sample_ready  out  1         holding register empty; transfer = valid & ready
//  sclk          out  1         I2S bit clock
//  ws            out  1         word select: 0 = left, 1 = right
//  sd            out  1         serial data; changes only on sclk falling edges
//  frame_start   out  1         1-clk pulse when position p enters 0
//  underrun      out  1         1-clk pulse: frame started with holding register empty
//  busy          out  1         1 while in RUN
// BEHAVIOUR
//  - Reset values: sclk=0, ws=0, sd=0, frame_start=0, underrun=0, busy=0, sample_ready=1.
//    Reset also sets hold empty, p=63, div_cnt=0, state=IDLE, shift register=0.
//    Reset mid-frame takes effect at the next clk edge and discards any held sample.
//  - FSM IDLE -> RUN when enable=1. RUN -> IDLE only at the falling edge that would
//    take p from 63 to 0 while enable=0; a frame in progress always completes.
//    In IDLE, sclk is held at 0, p=63 and div_cnt=0.
//  - Divider (RUN only):
//    - div_cnt counts 0..CLK_DIV-1.
//    - At CLK_DIV-1, sclk toggles and div_cnt returns to 0.
//    - First rising edge: CLK_DIV clks after entering RUN. First falling edge: 2*CLK_DIV clks.
//  - Frame position p (0..63) advances by one (mod 64) on each sclk falling edge.
//    Slot index k = p mod 32.
//  - ws = 1 iff p in 31..62, so ws changes one bit before each slot MSB (I2S).
//  - Data bits:
//    - sd = sample[SAMPLE_W-1-k] for k < SAMPLE_W, else 0. This holds in both slots.
//    - sd, ws and p update together on the same clk edge as the sclk 1->0 transition.
//    - The receiver samples on sclk rising edges.
//  - Frame-start load (edge entering p=0):
//    - Hold full: the shift/sample register <= hold and hold is marked empty.
//    - Hold empty: the sample register <= 0 and underrun pulses.
//    - frame_start pulses in both cases.
//  - Handshake: sample_ready = ~hold_full (registered state, no combinational path from valid).
//    - An accept while the hold is full is impossible because ready is low.
//    - If an accept and a frame-start load fall on the same clk, the load sees the
//      pre-edge (empty) hold: underrun fires and the new sample waits for the next frame.
//  - The sample is stable for a whole frame; a new accept never alters the frame in flight.
//  - Arithmetic: p is 6 bits and wraps 63->0; div_cnt is $clog2(CLK_DIV) bits.
//    No sign extension; unused slot bits are 0.
// TESTING
//  1. Assert rst for 2 clks mid-RUN -> next clk: sclk=ws=sd=0, busy=0, sample_ready=1,
//     hold empty.
//  2. Push 0xA7, then enable (CLK_DIV=4):
//     - First falling edge at clk 8: frame_start=1, underrun=0.
//     - sd at rising edges 0..7 = 1,0,1,0,0,1,1,1, then 24 zeros.
//     - ws rises at p=31; right slot repeats 0xA7; ws falls at p=63.
//  3. Enable with no sample -> underrun and frame_start pulse together at p=0;
//     sd=0 for all 64 bits; a sample pushed mid-frame appears in the next frame.
//  4. Push 0x80, then hold 0x7F valid -> 0x7F accepted only after the frame-0 load.
//     Frame 0 carries 0x80 (sd 1,0,0,0,0,0,0,0); frame 1 carries 0x7F.
//     Ready is low from 0x7F acceptance until the frame-1 load.
//  5. Deassert enable at p=10 -> frame finishes through p=63; then sclk stays 0,
//     busy=0, and no frame_start pulse occurs.
//  6. Sample accept on the same clk as a frame-start load with hold empty ->
//     underrun=1, that frame is all zero, and the sample is sent in the following frame.

Source files
------------

// File: rtl/team_06_i2s_to_dac.sv
// Philips I2S transmitter, mono: one buffered signed sample is sent MSB-first,
// left-justified in both 32-bit slots of a 64-bit frame; sclk and ws are generated here.
module team_06_i2s_to_dac #(
    parameter int CLK_DIV  = 4,
    parameter int SAMPLE_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid,
    output logic                sample_ready,
    output logic                sclk,
    output logic                ws,
    output logic                sd,
    output logic                frame_start,
    output logic                underrun,
    output logic                busy
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic [5:0]          p_q, p_d;
    logic                sclk_q, sclk_d;
    logic                ws_q, ws_d;
    logic                sd_q, sd_d;
    logic                frame_start_q, frame_start_d;
    logic                underrun_q, underrun_d;
    logic                busy_q, busy_d;
    logic                hold_full_q, hold_full_d;
    logic [SAMPLE_W-1:0] hold_q, hold_d;
    logic [SAMPLE_W-1:0] shift_q, shift_d;
    logic                accept_s;
    logic                load_s;

    // Bit of the left-justified 32-bit slot at slot index k (0 = MSB); zero below the sample.
    function automatic logic slot_bit(input logic [SAMPLE_W-1:0] smp, input logic [4:0] k);
        logic [31:0] slot;
        slot = 32'(smp) << (32 - SAMPLE_W);
        return slot[5'd31 - k];
    endfunction

    // Next-state logic for the FSM, bit-clock divider and frame position.
    always_comb begin
        state_d       = state_q;
        div_cnt_d     = div_cnt_q;
        p_d           = p_q;
        sclk_d        = sclk_q;
        ws_d          = ws_q;
        sd_d          = sd_q;
        frame_start_d = 1'b0;
        underrun_d    = 1'b0;
        shift_d       = shift_q;
        load_s        = 1'b0;
        case (state_q)
            IDLE: begin
                div_cnt_d = '0;
                sclk_d    = 1'b0;
                p_d       = 6'd63;
                if (enable) begin
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    sclk_d    = ~sclk_q;
                    if (sclk_q) begin
                        // Falling edge: a frame in progress always runs to p=63 before stopping.
                        if ((p_q == 6'd63) && !enable) begin
                            state_d = IDLE;
                        end else begin
                            p_d = p_q + 6'd1;
                            if (p_q == 6'd63) begin
                                load_s        = 1'b1;
                                frame_start_d = 1'b1;
                                if (hold_full_q) begin
                                    shift_d = hold_q;
                                end else begin
                                    shift_d    = '0;
                                    underrun_d = 1'b1;
                                end
                            end else begin
                                load_s = 1'b0;
                            end
                        end
                        ws_d = (p_d >= 6'd31) && (p_d <= 6'd62);
                        sd_d = slot_bit(shift_d, p_d[4:0]);
                    end else begin
                        ws_d = ws_q;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == RUN);
    end

    // Holding register: a frame-start load sees the pre-edge hold state, so a
    // same-cycle accept into an empty hold waits for the following frame.
    always_comb begin
        accept_s    = sample_valid & ~hold_full_q;
        hold_full_d = hold_full_q;
        hold_d      = hold_q;
        if (load_s && hold_full_q) begin
            hold_full_d = 1'b0;
        end else if (accept_s) begin
            hold_full_d = 1'b1;
            hold_d      = sample_in;
        end else begin
            hold_full_d = hold_full_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            div_cnt_q     <= '0;
            p_q           <= 6'd63;
            sclk_q        <= 1'b0;
            ws_q          <= 1'b0;
            sd_q          <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
            busy_q        <= 1'b0;
            hold_full_q   <= 1'b0;
            hold_q        <= '0;
            shift_q       <= '0;
        end else begin
            state_q       <= state_d;
            div_cnt_q     <= div_cnt_d;
            p_q           <= p_d;
            sclk_q        <= sclk_d;
            ws_q          <= ws_d;
            sd_q          <= sd_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
            busy_q        <= busy_d;
            hold_full_q   <= hold_full_d;
            hold_q        <= hold_d;
            shift_q       <= shift_d;
        end
    end

    assign sample_ready = ~hold_full_q;
    assign sclk         = sclk_q;
    assign ws           = ws_q;
    assign sd           = sd_q;
    assign frame_start  = frame_start_q;
    assign underrun     = underrun_q;
    assign busy         = busy_q;

endmodule
